// File: rtl/lcd_text_frame_show.sv
// Text-mode screen generator: a COLS x ROWS character/attribute buffer whose cells are handed to
// lcd_show_char one at a time. Optional macro DIRTY_TRACK_EN redraws only modified cells.
module lcd_text_frame_show #(
  parameter int COLS   = 20,
  parameter int ROWS   = 5,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int X_OFF  = 1,
  parameter int Y_OFF  = 0,
  localparam int CELLS = COLS * ROWS,
  localparam int AW    = $clog2(COLS * ROWS)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          init_done,
  input  logic          show_char_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  input  logic [1:0]    wr_attr,
  input  logic          pal_we,
  input  logic [1:0]    pal_idx,
  input  logic [15:0]   pal_bg,
  input  logic [15:0]   pal_fg,
  input  logic          refresh,
  output logic          en_size,
  output logic          show_char_flag,
  output logic [7:0]    ascii_num,
  output logic [8:0]    start_x,
  output logic [8:0]    start_y,
  output logic [15:0]   background_color,
  output logic [15:0]   front_color,
  output logic          busy
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOAD,
    FLAG,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    char_mem   [CELLS];
  logic [1:0]    attr_mem   [CELLS];
  logic [15:0]   palette_bg [4];
  logic [15:0]   palette_fg [4];

  logic [AW-1:0] scan_ptr;
  logic [CW-1:0] scan_col;
  logic [RW-1:0] scan_row;

  logic          wr_ok;
  logic          cell_sel;
  logic          advance;
  logic [7:0]    cell_code;
  logic [1:0]    cell_attr;
  logic [7:0]    font_code;
  logic [8:0]    x_pix;
  logic [8:0]    y_pix;

  assign en_size        = (CHAR_H == 16) ? 1'b1 : 1'b0;
  assign show_char_flag = (state == FLAG);
  assign wr_ok          = wr_en && (wr_addr <= LAST_CELL);

`ifdef DIRTY_TRACK_EN
  logic [CELLS-1:0] dirty;
  logic [CELLS-1:0] dirty_set;
  logic [CELLS-1:0] dirty_clr;

  assign cell_sel = dirty[scan_ptr];
  assign busy     = ((state != IDLE) && (state != SCAN)) || (|dirty);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    dirty_set = '0;
    dirty_clr = '0;
    if (wr_ok) dirty_set[wr_addr] = 1'b1;
    if (refresh || !init_done) dirty_set = '1;
    if (state == LOAD) dirty_clr[scan_ptr] = 1'b1;
  end

  // Set is applied after clear so a write landing on the cell being loaded keeps it pending.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dirty <= '1;
    else            dirty <= (dirty & ~dirty_clr) | dirty_set;
  end
`else
  logic unused_refresh;

  assign unused_refresh = refresh;
  assign cell_sel       = 1'b1;
  assign busy           = init_done;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!init_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SCAN;
        SCAN:    if (cell_sel) state_nxt = LOAD;
        LOAD:    state_nxt = FLAG;
        FLAG:    state_nxt = WAIT;
        WAIT:    if (show_char_done) state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The pointer parks on a selected cell through SCAN and steps past it in LOAD, so the next
  // scan begins at (last drawn)+1. Column/row track it to avoid a divider.
  assign advance = (state == LOAD) || ((state == SCAN) && init_done && !cell_sel);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_ptr <= '0;
      scan_col <= '0;
      scan_row <= '0;
    end else if (advance) begin
      if (scan_ptr == LAST_CELL) begin
        scan_ptr <= '0;
        scan_col <= '0;
        scan_row <= '0;
      end else begin
        scan_ptr <= scan_ptr + 1'b1;
        if (scan_col == LAST_COL) begin
          scan_col <= '0;
          scan_row <= scan_row + 1'b1;
        end else begin
          scan_col <= scan_col + 1'b1;
        end
      end
    end
  end

  // NOTE: the buffer is built from flops and reset, because the screen must come up as blanks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        char_mem[i] <= 8'h20;
        attr_mem[i] <= 2'd0;
      end
    end else if (wr_ok) begin
      char_mem[wr_addr] <= wr_char;
      attr_mem[wr_addr] <= wr_attr;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      palette_bg[0] <= 16'hAF7D;
      palette_fg[0] <= 16'h0000;
      palette_bg[1] <= 16'h815B;
      palette_fg[1] <= 16'hFFFF;
      palette_bg[2] <= 16'hFA20;
      palette_fg[2] <= 16'hFFFF;
      palette_bg[3] <= 16'hE73F;
      palette_fg[3] <= 16'h0000;
    end else if (pal_we) begin
      palette_bg[pal_idx] <= pal_bg;
      palette_fg[pal_idx] <= pal_fg;
    end
  end

  always_comb begin
    cell_code = char_mem[scan_ptr];
    cell_attr = attr_mem[scan_ptr];
    font_code = 8'd0;
    if ((cell_code >= 8'd32) && (cell_code <= 8'd126)) font_code = cell_code - 8'd32;
    x_pix = 9'(X_OFF + int'(scan_col) * CHAR_W);
    y_pix = 9'(Y_OFF + int'(scan_row) * CHAR_H);
  end

  // Glyph outputs change only in LOAD, so they stay frozen for lcd_show_char during FLAG/WAIT.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ascii_num        <= 8'd0;
      start_x          <= 9'd0;
      start_y          <= 9'd0;
      background_color <= 16'd0;
      front_color      <= 16'd0;
    end else if (state == LOAD) begin
      ascii_num        <= font_code;
      start_x          <= x_pix;
      start_y          <= y_pix;
      background_color <= palette_bg[cell_attr];
      front_color      <= palette_fg[cell_attr];
    end
  end

endmodule

// File: tb/tb_lcd_text_frame_show.sv
// Randomised self-checking bench for lcd_text_frame_show against a cell-level screen model.
// Build with or without DIRTY_TRACK_EN to match the design.
module tb_lcd_text_frame_show;

  localparam int NCELL = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_done;
  logic        show_char_done;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_char;
  logic [1:0]  wr_attr;
  logic        pal_we;
  logic [1:0]  pal_idx;
  logic [15:0] pal_bg;
  logic [15:0] pal_fg;
  logic        refresh;
  logic        en_size;
  logic        show_char_flag;
  logic [7:0]  ascii_num;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic [15:0] background_color;
  logic [15:0] front_color;
  logic        busy;

  logic [57:0] dut_out;
  logic [57:0] cur_out;

  int checks = 0;
  int errors = 0;

  int          m_char  [NCELL];
  int          m_attr  [NCELL];
  bit          m_dirty [NCELL];
  logic [15:0] m_bg    [4];
  logic [15:0] m_fg    [4];
  int          m_last;

  lcd_text_frame_show dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .init_done        (init_done),
    .show_char_done   (show_char_done),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_char          (wr_char),
    .wr_attr          (wr_attr),
    .pal_we           (pal_we),
    .pal_idx          (pal_idx),
    .pal_bg           (pal_bg),
    .pal_fg           (pal_fg),
    .refresh          (refresh),
    .en_size          (en_size),
    .show_char_flag   (show_char_flag),
    .ascii_num        (ascii_num),
    .start_x          (start_x),
    .start_y          (start_y),
    .background_color (background_color),
    .front_color      (front_color),
    .busy             (busy)
  );

  assign dut_out = {ascii_num, start_x, start_y, background_color, front_color};

  always #5 sys_clk = ~sys_clk;

  function automatic void model_reset();
    for (int i = 0; i < NCELL; i++) begin
      m_char[i]  = 32;
      m_attr[i]  = 0;
      m_dirty[i] = 1'b1;
    end
    m_bg   = '{16'hAF7D, 16'h815B, 16'hFA20, 16'hE73F};
    m_fg   = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    m_last = NCELL - 1;
  endfunction

  function automatic int model_next();
`ifdef DIRTY_TRACK_EN
    int c;
    for (int k = 1; k <= NCELL; k++) begin
      c = (m_last + k) % NCELL;
      if (m_dirty[c]) return c;
    end
    return -1;
`else
    return (m_last + 1) % NCELL;
`endif
  endfunction

  function automatic logic [57:0] model_out(input int idx);
    int c, code, x, y, a;
    c    = m_char[idx];
    code = (c >= 32 && c <= 126) ? c - 32 : 0;
    x    = 1 + (idx % 20) * 8;
    y    = (idx / 20) * 16;
    a    = m_attr[idx];
    return {8'(code), 9'(x), 9'(y), m_bg[a], m_fg[a]};
  endfunction

  task automatic expect_flag(output int idx, output int waited);
    logic [57:0] exp_v;
    bit seen;
    seen   = 1'b0;
    idx    = model_next();
    waited = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sys_clk);
      waited = i + 1;
      seen   = show_char_flag;
    end
    checks++;
    if (!seen || idx < 0) begin
      errors++;
      $display("FAIL flag_wait: flag seen=%0d, required a flag for cell %0d", seen, idx);
      idx = -1;
      return;
    end
    exp_v   = model_out(idx);
    cur_out = dut_out;
    checks++;
    if (dut_out !== exp_v) begin
      errors++;
      $display("FAIL cell_%0d: got ascii=%0d x=%0d y=%0d bg=%h fg=%h, required ascii=%0d x=%0d y=%0d bg=%h fg=%h",
               idx, dut_out[57:50], dut_out[49:41], dut_out[40:32], dut_out[31:16], dut_out[15:0],
               exp_v[57:50], exp_v[49:41], exp_v[40:32], exp_v[31:16], exp_v[15:0]);
    end
    m_dirty[idx] = 1'b0;
    m_last       = idx;
  endtask

  task automatic ack(input int dly);
    @(negedge sys_clk);
    checks++;
    if (show_char_flag !== 1'b0) begin
      errors++;
      $display("FAIL flag_width: show_char_flag=%b after its pulse, required 0", show_char_flag);
    end
    repeat (dly) @(negedge sys_clk);
    checks++;
    if (dut_out !== cur_out) begin
      errors++;
      $display("FAIL hold_in_wait: outputs %h, required %h", dut_out, cur_out);
    end
    show_char_done = 1'b1;
    @(negedge sys_clk);
    show_char_done = 1'b0;
  endtask

  task automatic host_write(input int addr, input int c, input int a);
    wr_en   = 1'b1;
    wr_addr = 7'(addr);
    wr_char = 8'(c);
    wr_attr = 2'(a);
    @(negedge sys_clk);
    wr_en = 1'b0;
    if (addr < NCELL) begin
      m_char[addr]  = c;
      m_attr[addr]  = a;
      m_dirty[addr] = 1'b1;
    end
  endtask

  task automatic pal_write(input int idx, input logic [15:0] bg, input logic [15:0] fg);
    pal_we  = 1'b1;
    pal_idx = 2'(idx);
    pal_bg  = bg;
    pal_fg  = fg;
    @(negedge sys_clk);
    pal_we    = 1'b0;
    m_bg[idx] = bg;
    m_fg[idx] = fg;
  endtask

  task automatic do_refresh();
    refresh = 1'b1;
    @(negedge sys_clk);
    refresh = 1'b0;
`ifdef DIRTY_TRACK_EN
    for (int i = 0; i < NCELL; i++) m_dirty[i] = 1'b1;
`endif
  endtask

  // Writes land only while the scheduler is parked (idle scan or WAIT) so drawing order is defined.
  task automatic kick_write(input int addr, input int c, input int a);
    int idx, w;
    if (model_next() < 0) begin
      host_write(addr, c, a);
    end else begin
      expect_flag(idx, w);
      host_write(addr, c, a);
      ack(2);
    end
  endtask

  task automatic run_to(input int target);
    int idx, w;
    for (int n = 0; n < NCELL && model_next() != target; n++) begin
      expect_flag(idx, w);
      ack(1);
    end
    expect_flag(idx, w);
  endtask

  task automatic test_reset();
    int flags;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({show_char_flag, dut_out} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs: got flag=%b out=%h, required all 0", show_char_flag, dut_out);
    end
    checks++;
    if (en_size !== 1'b1) begin
      errors++;
      $display("FAIL en_size: got %b, required 1", en_size);
    end
    checks++;
`ifdef DIRTY_TRACK_EN
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 1", busy);
    end
`else
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
`endif
    sys_rst_n = 1'b1;
    flags = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (show_char_flag) flags++;
    end
    checks++;
    if (flags !== 0) begin
      errors++;
      $display("FAIL idle_before_init: got %0d flags, required 0", flags);
    end
  endtask

  task automatic test_full_frame();
    int idx, w, flags;
    init_done = 1'b1;
    expect_flag(idx, w);
    checks++;
    if (cur_out !== {8'd0, 9'd1, 9'd0, 16'hAF7D, 16'h0000}) begin
      errors++;
      $display("FAIL first_cell: got %h, required ascii 0 x 1 y 0 AF7D/0000", cur_out);
    end
    ack(10);
    for (int n = 1; n < NCELL; n++) begin
      expect_flag(idx, w);
      ack(10);
    end
    checks++;
`ifdef DIRTY_TRACK_EN
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_frame: got %b, required 0", busy);
    end
    flags = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (show_char_flag) flags++;
    end
    checks++;
    if (flags !== 0) begin
      errors++;
      $display("FAIL quiet_when_clean: got %0d flags, required 0", flags);
    end
`else
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_continuous: got %b, required 1", busy);
    end
`endif
  endtask

  task automatic test_single_write();
    kick_write(21, 65, 1);
    run_to(21);
    checks++;
    if (cur_out !== {8'd33, 9'd9, 9'd16, 16'h815B, 16'hFFFF}) begin
      errors++;
      $display("FAIL write_A_21: got %h, required ascii 33 x 9 y 16 815B/FFFF", cur_out);
    end
    ack(3);
  endtask

  task automatic test_write_during_wait();
    kick_write(5, 48, 0);
    run_to(5);
    checks++;
    if (cur_out[57:50] !== 8'd16) begin
      errors++;
      $display("FAIL cell5_first: got ascii %0d, required 16", cur_out[57:50]);
    end
    host_write(5, 49, 0);
    ack(5);
    run_to(5);
    checks++;
    if (cur_out[57:50] !== 8'd17) begin
      errors++;
      $display("FAIL cell5_redraw: got ascii %0d, required 17", cur_out[57:50]);
    end
    ack(3);
  endtask

  task automatic test_nonprint_palette_refresh();
    int idx, w;
    kick_write(3, 8'h07, 2);
    run_to(3);
    checks++;
    if (cur_out[57:50] !== 8'd0) begin
      errors++;
      $display("FAIL nonprint: got ascii %0d, required 0", cur_out[57:50]);
    end
    pal_write(2, 16'h001F, 16'hFFFF);
    do_refresh();
    ack(4);
    for (int n = 0; n < NCELL; n++) begin
      expect_flag(idx, w);
      if (idx == 3) begin
        checks++;
        if (cur_out[31:16] !== 16'h001F) begin
          errors++;
          $display("FAIL palette_refresh: got bg %h, required 001F", cur_out[31:16]);
        end
      end
      ack(1);
    end
  endtask

  task automatic test_init_drop();
    int idx, w, flags;
    kick_write(50, 90, 3);
    expect_flag(idx, w);
    repeat (3) @(negedge sys_clk);
    init_done = 1'b0;
`ifdef DIRTY_TRACK_EN
    for (int i = 0; i < NCELL; i++) m_dirty[i] = 1'b1;
`endif
    flags = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (show_char_flag) flags++;
    end
    checks++;
    if (flags !== 0) begin
      errors++;
      $display("FAIL init_drop_flag: got %0d flags, required 0", flags);
    end
    checks++;
`ifdef DIRTY_TRACK_EN
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL init_drop_busy: got %b, required 1", busy);
    end
`else
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_drop_busy: got %b, required 0", busy);
    end
`endif
    init_done = 1'b1;
    for (int n = 0; n < NCELL; n++) begin
      expect_flag(idx, w);
      ack(1);
    end
  endtask

  task automatic test_random();
    int idx, w, nw;
    for (int k = 0; k < 40; k++) begin
`ifdef DIRTY_TRACK_EN
      if (model_next() < 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_busy: got %b, required 0", busy);
        end
        host_write($urandom_range(0, NCELL - 1), $urandom_range(0, 255), $urandom_range(0, 3));
      end
`endif
      expect_flag(idx, w);
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++)
        host_write($urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        pal_write($urandom_range(0, 3), 16'($urandom), 16'($urandom));
      ack($urandom_range(0, 5));
    end
  endtask

`ifndef DIRTY_TRACK_EN
  task automatic test_continuous_wrap();
    int idx, w;
    for (int n = 0; n < 250; n++) begin
      expect_flag(idx, w);
      checks++;
      if (w !== 2) begin
        errors++;
        $display("FAIL scan_gap: flag %0d cycles after done, required 2", w);
      end
      ack($urandom_range(0, 3));
    end
  endtask
`endif

  initial begin
    sys_rst_n      = 1'b0;
    init_done      = 1'b0;
    show_char_done = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_char        = '0;
    wr_attr        = '0;
    pal_we         = 1'b0;
    pal_idx        = '0;
    pal_bg         = '0;
    pal_fg         = '0;
    refresh        = 1'b0;
    model_reset();
    test_reset();
    test_full_frame();
    test_single_write();
    test_write_during_wait();
    test_nonprint_palette_refresh();
    test_init_drop();
    test_random();
`ifndef DIRTY_TRACK_EN
    test_continuous_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
